button_debouncer: RTL



---
 rtl/button_debouncer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : button_debouncer
//  Brief    : Multi-channel debouncer and edge detector for the front-panel
//             buttons. Each channel filters an already-synchronized level and
//             emits a debounced level plus one-cycle press/release pulses.
//  Revision : 1.0  initial release
// ============================================================================
// Note: the falling-edge pulse output is named release_pulse because
// "release" is a reserved word in SystemVerilog.
module button_debouncer #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_pulse,
  output logic         any_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  // Last count value before a level change is accepted.
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_WAIT = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_WAIT = 2'd3
  } state_t;

  // Next-cycle press bits from every channel, used to register any_press
  // in the same cycle the press bits themselves are registered.
  logic [N-1:0] w_press_nxt;
  logic         r_any_press;

  generate
    for (genvar g = 0; g < N; g++) begin : g_chan
      state_t           r_state;
      state_t           w_state_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic             r_level;
      logic             r_press;
      logic             r_release;
      logic             w_level_nxt;
      logic             w_press_ch;
      logic             w_release_ch;

      // State, counter and registered outputs; reset discards everything,
      // including a HIGH level, without generating a release pulse.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_state   <= S_LOW;
          r_cnt     <= '0;
          r_level   <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_state   <= w_state_nxt;
          r_cnt     <= w_cnt_nxt;
          r_level   <= w_level_nxt;
          r_press   <= w_press_ch;
          r_release <= w_release_ch;
        end
      end

      // Next-state, counter and pulse decode; any bounce restarts the count.
      always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_level_nxt  = r_level;
        w_press_ch   = 1'b0;
        w_release_ch = 1'b0;
        case (r_state)
          S_LOW: begin
            w_level_nxt = 1'b0;
            if (in[g]) begin
              w_state_nxt = S_RISE_WAIT;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
          S_RISE_WAIT: begin
            w_level_nxt = 1'b0;
            if (!in[g]) begin
              w_state_nxt = S_LOW;
              w_cnt_nxt   = '0;
            end else if (r_cnt == C_CNT_LAST) begin
              w_state_nxt = S_HIGH;
              w_cnt_nxt   = '0;
              w_level_nxt = 1'b1;
              w_press_ch  = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
          S_HIGH: begin
            w_level_nxt = 1'b1;
            if (!in[g]) begin
              w_state_nxt = S_FALL_WAIT;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
          S_FALL_WAIT: begin
            w_level_nxt = 1'b1;
            if (in[g]) begin
              w_state_nxt = S_HIGH;
              w_cnt_nxt   = '0;
            end else if (r_cnt == C_CNT_LAST) begin
              w_state_nxt  = S_LOW;
              w_cnt_nxt    = '0;
              w_level_nxt  = 1'b0;
              w_release_ch = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
          default: begin
            w_state_nxt = S_LOW;
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b0;
          end
        endcase
      end

      assign w_press_nxt[g]   = w_press_ch;
      assign level[g]         = r_level;
      assign press[g]         = r_press;
      assign release_pulse[g] = r_release;
    end
  endgenerate

  // Aggregate press flag, registered alongside the per-channel press bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_any_press <= 1'b0;
    end else begin
      r_any_press <= |w_press_nxt;
    end
  end

  assign any_press = r_any_press;

endmodule
`default_nettype wire
